// File: rtl/l1_req_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_req_master_pkg
// Description : Shared definitions for the L1 request master: FSM state
//               encodings, cache response codes and the address/data width
//               defaults used on the L1 request channel.
// Revision    : 1.0 - initial release
// ============================================================================
package l1_req_master_pkg;

    // Width defaults, kept in step with the L1 cache slave
    localparam int c_DEFAULT_ADDR_W = 20;
    localparam int c_DEFAULT_DATA_W = 32;

    // Cache response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Request FSM state encodings
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT_W = 3'd2,
        ST_WAIT_R = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage : l1_req_master_pkg
`default_nettype wire

// File: rtl/l1_req_master_req.sv
`default_nettype none
// ============================================================================
// Module      : req_fifo
// Description : Synchronous FIFO holding queued {we, addr, wdata} commands.
//               Pointers carry one extra wrap bit so full and empty can be
//               told apart without a separate occupancy counter.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push, i_din - write strobe and entry (ignored when full)
//               i_pop         - read strobe (ignored when empty)
//               o_dout        - head entry (valid when !o_empty)
//               o_full        - no free slot
//               o_empty       - no entry present
// Revision    : 1.0 - initial release
// ============================================================================
module req_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Same index with differing wrap bits means the writer lapped the reader
    assign o_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_dout  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_din;
        end
    end

endmodule : req_fifo
`default_nettype wire

// File: rtl/l1_req_master.sv
`default_nettype none
// ============================================================================
// Module      : l1_req_master
// Description : Core-side initiator for the L1 data cache request channel.
//               Queues load/store commands, issues them one at a time, waits
//               for the write hit/response or read data (with a read
//               timeout), returns one completion per command and keeps
//               saturating hit/miss statistics.
// Ports       : clk, rst                    - clock, sync active-high reset
//               cmd_*                        - command queue (valid/ready)
//               rsp_*                        - completion port (valid/ready)
//               data_addr, wdata, awvalid,
//               wvalid, arvalid              - request channel to the cache
//               rvalid, rdata, w_hit, r_hit,
//               w_resp, r_resp               - cache results
//               hit_cnt, miss_cnt            - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module l1_req_master
    import l1_req_master_pkg::*;
#(
    parameter int ADDR_W     = c_DEFAULT_ADDR_W,
    parameter int DATA_W     = c_DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_LAT     = 1,
    parameter int RD_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              awvalid,
    output logic              wvalid,
    output logic              arvalid,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              w_hit,
    input  logic              r_hit,
    input  logic [1:0]        w_resp,
    input  logic [1:0]        r_resp,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int                 c_ENTRY_W  = 1 + ADDR_W + DATA_W;
    localparam int                 c_LAT_W    = 3;
    localparam int                 c_TMR_W    = $clog2(RD_TIMEOUT) + 1;
    localparam logic [c_LAT_W-1:0] c_WR_LAT   = c_LAT_W'(WR_LAT);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE  = c_LAT_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(RD_TIMEOUT - 1);
    localparam logic [15:0]        c_CNT_MAX  = 16'hFFFF;

    logic [c_ENTRY_W-1:0] w_head;
    logic                 w_head_we;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [DATA_W-1:0]    w_head_wdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic                 w_wr_done;
    logic                 w_rd_done;
    logic                 w_stat_hit;
    logic                 w_stat_miss;

    state_t               r_state;
    logic                 r_we;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic [c_TMR_W-1:0]   r_timer;
    logic [15:0]          r_hit_cnt;
    logic [15:0]          r_miss_cnt;

    req_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_din   ({cmd_we, cmd_addr, cmd_wdata}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign cmd_ready    = !w_fifo_full;
    assign w_head_we    = w_head[c_ENTRY_W-1];
    assign w_head_addr  = w_head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign w_head_wdata = w_head[DATA_W-1:0];
    assign w_pop        = (r_state == ST_IDLE) && !w_fifo_empty && !rsp_valid;

    // Completion events that feed the statistics; timeouts are excluded
    assign w_wr_done   = (r_state == ST_WAIT_W) && (r_lat_cnt == c_LAT_ONE);
    assign w_rd_done   = (r_state == ST_WAIT_R) && rvalid;
    assign w_stat_hit  = (w_wr_done && w_hit) || (w_rd_done && r_hit);
    assign w_stat_miss = (w_wr_done && !w_hit) || (w_rd_done && !r_hit);

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_lat_cnt   <= '0;
            r_timer     <= '0;
            data_addr   <= '0;
            wdata       <= '0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            arvalid     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_hit     <= 1'b0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            // Request valids are one-cycle pulses covering ISSUE only
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            arvalid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_we      <= w_head_we;
                        data_addr <= w_head_addr;
                        wdata     <= w_head_we ? w_head_wdata : '0;
                        awvalid   <= w_head_we;
                        wvalid    <= w_head_we;
                        arvalid   <= !w_head_we;
                        r_timer   <= '0;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // The ISSUE cycle counts towards the read timeout
                    r_timer   <= r_timer + c_TMR_ONE;
                    r_lat_cnt <= c_WR_LAT;
                    r_state   <= r_we ? ST_WAIT_W : ST_WAIT_R;
                end

                ST_WAIT_W: begin
                    r_lat_cnt <= r_lat_cnt - c_LAT_ONE;
                    if (w_wr_done) begin
                        rsp_valid   <= 1'b1;
                        rsp_we      <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_hit     <= w_hit;
                        rsp_resp    <= w_resp;
                        rsp_timeout <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end

                ST_WAIT_R: begin
                    r_timer <= r_timer + c_TMR_ONE;
                    // Data arriving on the last allowed cycle beats the timeout
                    if (rvalid) begin
                        rsp_valid   <= 1'b1;
                        rsp_we      <= 1'b0;
                        rsp_rdata   <= rdata;
                        rsp_hit     <= r_hit;
                        rsp_resp    <= r_resp;
                        rsp_timeout <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (r_timer == c_TMR_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_we      <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_hit     <= 1'b0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_timeout <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_stat_hit && (r_hit_cnt != c_CNT_MAX)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_stat_miss && (r_miss_cnt != c_CNT_MAX)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

endmodule : l1_req_master
`default_nettype wire
